// File: rtl/regset_write_sched.sv
// regset_write_sched: clears the 64-entry register set after reset, then
// arbitrates the single write port between core writeback (always wins)
// and a small in-order late-write FIFO. Reports pending late writes on the
// two read addresses so the pipeline can interlock.
module regset_write_sched #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              init_busy,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              wb_grubby,
  input  logic              late_valid,
  output logic              late_ready,
  input  logic [ADDR_W-1:0] late_addr,
  input  logic [31:0]       late_data,
  input  logic              late_grubby,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              pend1,
  output logic              pend2,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              wg
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;

  logic [ADDR_W-1:0]   f_addr_r [FIFO_DEPTH];
  logic [31:0]         f_data_r [FIFO_DEPTH];
  logic                f_tag_r  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_vld_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;

  logic run_s;
  logic not_empty_s;
  logic push_s;
  logic pop_s;

  assign run_s       = (state_r == ST_RUN);
  assign not_empty_s = (count_r != {(PTR_W + 1){1'b0}});
  // Ready depends on registered state only; no path from late_valid.
  assign late_ready  = run_s && (count_r < CNT_FULL);
  assign push_s      = late_valid && late_ready;
  // The head leaves the FIFO whenever the core is not using the port,
  // including superseded heads which then leave the port idle.
  assign pop_s       = run_s && !wb_valid && not_empty_s;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: leave CLEAR after the last entry is written; RUN is terminal.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_CLEAR;
    endcase
  end

  // Clear address counter, advancing once per CLEAR cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Write-port mux: clear sweep, then writeback over FIFO head.
  always_comb begin
    init_busy = 1'b1;
    we        = 1'b0;
    wa        = {ADDR_W{1'b0}};
    wd        = 32'h0000_0000;
    wg        = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        init_busy = 1'b1;
        we        = 1'b1;
        wa        = ADDR_W'(cnt_r);
      end
      ST_RUN: begin
        init_busy = 1'b0;
        if (wb_valid) begin
          we = 1'b1;
          wa = wb_addr;
          wd = wb_data;
          wg = wb_grubby;
        end else if (not_empty_s && f_vld_r[rd_ptr_r]) begin
          we = 1'b1;
          wa = f_addr_r[rd_ptr_r];
          wd = f_data_r[rd_ptr_r];
          wg = f_tag_r[rd_ptr_r];
        end else begin
          we = 1'b0;
        end
      end
      default: begin
        init_busy = 1'b1;
        we        = 1'b0;
      end
    endcase
  end

  // Hazard flags: any still-valid buffered write to a nonzero read address.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (f_vld_r[i] && (f_addr_r[i] == ra1)) begin
        pend1 = 1'b1;
      end else begin
        pend1 = pend1;
      end
      if (f_vld_r[i] && (f_addr_r[i] == ra2)) begin
        pend2 = 1'b1;
      end else begin
        pend2 = pend2;
      end
    end
    if (ra1 == {ADDR_W{1'b0}}) begin
      pend1 = 1'b0;
    end else begin
      pend1 = pend1;
    end
    if (ra2 == {ADDR_W{1'b0}}) begin
      pend2 = 1'b0;
    end else begin
      pend2 = pend2;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Per-entry valid: set on push, cleared on pop or by a younger writeback
  // to the same address. A push into a slot wins over invalidation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_vld_r <= {FIFO_DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push_s && (wr_ptr_r == PTR_W'(i))) begin
          f_vld_r[i] <= 1'b1;
        end else if (pop_s && (rd_ptr_r == PTR_W'(i))) begin
          f_vld_r[i] <= 1'b0;
        end else if (run_s && wb_valid && (f_addr_r[i] == wb_addr)) begin
          f_vld_r[i] <= 1'b0;
        end else begin
          f_vld_r[i] <= f_vld_r[i];
        end
      end
    end
  end

  // FIFO payload storage, written at the tail on push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_addr_r[i] <= {ADDR_W{1'b0}};
        f_data_r[i] <= 32'h0000_0000;
        f_tag_r[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push_s && (wr_ptr_r == PTR_W'(i))) begin
          f_addr_r[i] <= late_addr;
          f_data_r[i] <= late_data;
          f_tag_r[i]  <= late_grubby;
        end else begin
          f_addr_r[i] <= f_addr_r[i];
          f_data_r[i] <= f_data_r[i];
          f_tag_r[i]  <= f_tag_r[i];
        end
      end
    end
  end

endmodule
